// File: rtl/gpu_sched_pkg.sv
// rtl/gpu_sched_pkg.sv - shared types and width helpers for the kernel block scheduler
package gpu_sched_pkg;

    // Kernel-level state: waiting for launch, dispatching blocks, finished
    typedef enum logic [1:0] {
        TOP_IDLE = 2'd0,
        TOP_RUN  = 2'd1,
        TOP_DONE = 2'd2
    } top_state_t;

    // Per-core slot state; KILL is the single reset cycle issued on abort
    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_RESET  = 2'd1,
        SLOT_ACTIVE = 2'd2,
        SLOT_KILL   = 2'd3
    } slot_state_t;

    // Width of a per-core thread-count field (must hold THREADS_PER_BLOCK itself)
    function automatic int thread_field_bits(input int threads_per_block);
        return $clog2(threads_per_block) + 1;
    endfunction

    // Width of block counters; one extra bit so ceil(T/TPB) never overflows
    function automatic int block_count_bits(input int thread_count_bits);
        return thread_count_bits + 1;
    endfunction

    // Width of the round-robin pointer, at least one bit
    function automatic int ptr_bits(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

    localparam int DEF_THREADS_PER_BLOCK = 4;
    localparam int DEF_THREAD_COUNT_BITS = 8;
    localparam int THREAD_FIELD_BITS     = $clog2(DEF_THREADS_PER_BLOCK) + 1;
    localparam int BLOCK_COUNT_BITS      = DEF_THREAD_COUNT_BITS + 1;

endpackage

// File: rtl/block_scheduler_rr_arbiter.sv
// rtl/block_scheduler_rr_arbiter.sv - combinational round-robin arbiter, first request at or after ptr
module rr_arbiter #(
    parameter int N        = 2,
    parameter int PTR_BITS = 1
) (
    input  logic [N-1:0]        req,
    input  logic [PTR_BITS-1:0] ptr,
    output logic [N-1:0]        grant
);

    // Scan from the pointer upward with wrap; grant the first requester found
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (grant == '0 && req[j]) begin
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_scheduler.sv
// rtl/block_scheduler.sv - kernel block scheduler with round-robin core assignment, abort and cycle counter
module block_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 8,
    parameter int BLOCK_ID_BITS     = 8,
    parameter int CYCLE_BITS        = 32
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic                                                        start,
    input  logic                                                        abort,
    input  logic [THREAD_COUNT_BITS-1:0]                                thread_count,
    input  logic [NUM_CORES-1:0]                                        core_done,
    output logic [NUM_CORES-1:0]                                        core_reset,
    output logic [NUM_CORES-1:0]                                        core_start,
    output logic [NUM_CORES*BLOCK_ID_BITS-1:0]                          core_block_id,
    output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0]          core_thread_count,
    output logic                                                        busy,
    output logic                                                        done,
    output logic [CYCLE_BITS-1:0]                                       cycle_count
);

    localparam int TF_BITS  = thread_field_bits(THREADS_PER_BLOCK);
    localparam int BLK_BITS = block_count_bits(THREAD_COUNT_BITS);
    localparam int PTR_BITS = ptr_bits(NUM_CORES);
    localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);

    top_state_t                 state;
    top_state_t                 state_next;
    logic                       start_q;
    logic [BLK_BITS-1:0]        total_blocks;
    logic [BLK_BITS-1:0]        next_block;
    logic [BLK_BITS-1:0]        blocks_done;
    logic [BLK_BITS-1:0]        done_sum;
    logic [TF_BITS-1:0]         last_threads;
    logic [CYCLE_BITS-1:0]      cycle_cnt;
    logic [PTR_BITS-1:0]        rr_ptr;
    logic [PTR_BITS-1:0]        grant_idx;
    logic [PTR_BITS-1:0]        ptr_next;
    logic [NUM_CORES-1:0]       slot_free;
    logic [NUM_CORES-1:0]       grant;
    logic [NUM_CORES-1:0]       done_accept;
    logic                       launch;
    logic                       run_abort;
    logic                       assign_fire;
    logic                       all_free;
    logic [BLOCK_ID_BITS-1:0]   assign_id;
    logic [TF_BITS-1:0]         assign_threads;
    logic [BLK_BITS-1:0]        total_calc;
    logic [THREAD_COUNT_BITS-1:0] tc_rem;
    logic [TF_BITS-1:0]         last_calc;

    rr_arbiter #(
        .N        (NUM_CORES),
        .PTR_BITS (PTR_BITS)
    ) u_arb (
        .req   (slot_free),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Launch-time sizing, assignment qualifiers and per-cycle completion count
    always_comb begin
        total_calc     = ({1'b0, thread_count} + BLK_BITS'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB;
        tc_rem         = thread_count & THREAD_COUNT_BITS'(THREADS_PER_BLOCK - 1);
        last_calc      = (tc_rem == '0) ? TF_BITS'(THREADS_PER_BLOCK) : TF_BITS'(tc_rem);
        launch         = (state == TOP_IDLE) && start && !start_q;
        run_abort      = (state == TOP_RUN) && abort;
        all_free       = &slot_free;
        assign_fire    = (state == TOP_RUN) && !abort && (next_block < total_blocks) && (|grant);
        assign_id      = BLOCK_ID_BITS'(next_block);
        assign_threads = (next_block == total_blocks - BLK_BITS'(1)) ? last_threads
                                                                     : TF_BITS'(THREADS_PER_BLOCK);
        grant_idx      = '0;
        done_sum       = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (grant[k]) begin
                grant_idx = PTR_BITS'(k);
            end
            done_sum = done_sum + BLK_BITS'(done_accept[k]);
        end
        ptr_next = (grant_idx == PTR_BITS'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_BITS'(1);
    end

    // Top FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= TOP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Top FSM next state: abort wins over completion while running
    always_comb begin
        state_next = state;
        case (state)
            TOP_IDLE: if (launch) state_next = TOP_RUN;
            TOP_RUN: begin
                if (abort) begin
                    state_next = TOP_IDLE;
                end else if (blocks_done == total_blocks && all_free) begin
                    state_next = TOP_DONE;
                end
            end
            TOP_DONE: if (!start) state_next = TOP_IDLE;
            default:  state_next = TOP_IDLE;
        endcase
    end

    // Kernel bookkeeping: launch latch, block counters, pointer and saturating cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q      <= 1'b0;
            total_blocks <= '0;
            last_threads <= '0;
            next_block   <= '0;
            blocks_done  <= '0;
            cycle_cnt    <= '0;
            rr_ptr       <= '0;
        end else begin
            start_q <= start;
            if (launch) begin
                total_blocks <= total_calc;
                last_threads <= last_calc;
                next_block   <= '0;
                blocks_done  <= '0;
                cycle_cnt    <= '0;
            end else if (state == TOP_RUN && !abort) begin
                if (cycle_cnt != '1) begin
                    cycle_cnt <= cycle_cnt + CYCLE_BITS'(1);
                end
                blocks_done <= blocks_done + done_sum;
                if (assign_fire) begin
                    next_block <= next_block + BLK_BITS'(1);
                    rr_ptr     <= ptr_next;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_slot
        slot_state_t              slot_state;
        slot_state_t              slot_next;
        logic [BLOCK_ID_BITS-1:0] slot_id;
        logic [TF_BITS-1:0]       slot_tc;

        // Slot next state: abort forces a one-cycle kill on any occupied slot
        always_comb begin
            slot_next = slot_state;
            if (run_abort && slot_state != SLOT_FREE) begin
                slot_next = SLOT_KILL;
            end else begin
                case (slot_state)
                    SLOT_FREE:   if (assign_fire && grant[k]) slot_next = SLOT_RESET;
                    SLOT_RESET:  slot_next = SLOT_ACTIVE;
                    SLOT_ACTIVE: if (done_accept[k]) slot_next = SLOT_FREE;
                    SLOT_KILL:   slot_next = SLOT_FREE;
                    default:     slot_next = SLOT_FREE;
                endcase
            end
        end

        // Slot state register plus the block id / thread count captured at assignment
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                slot_state <= SLOT_FREE;
                slot_id    <= '0;
                slot_tc    <= '0;
            end else begin
                slot_state <= slot_next;
                if (assign_fire && grant[k]) begin
                    slot_id <= assign_id;
                    slot_tc <= assign_threads;
                end
            end
        end

        assign slot_free[k]   = (slot_state == SLOT_FREE);
        assign done_accept[k] = (slot_state == SLOT_ACTIVE) && core_done[k] && (state == TOP_RUN) && !abort;
        assign core_reset[k]  = (slot_state == SLOT_RESET) || (slot_state == SLOT_KILL);
        assign core_start[k]  = (slot_state == SLOT_ACTIVE);
        assign core_block_id[k*BLOCK_ID_BITS +: BLOCK_ID_BITS] = slot_id;
        assign core_thread_count[k*TF_BITS +: TF_BITS]         = slot_tc;
    end

    assign busy        = (state == TOP_RUN);
    assign done        = (state == TOP_DONE);
    assign cycle_count = cycle_cnt;

endmodule

// File: tb/tb_block_scheduler.sv
// tb/tb_block_scheduler.sv - self-checking bench for block_scheduler against a behavioural kernel model
module tb_block_scheduler;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TCB = 8;
    localparam int BIB = 8;
    localparam int CB  = 32;
    localparam int TFB = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic [TCB-1:0]       thread_count;
    logic [NC-1:0]        core_done;
    logic [NC-1:0]        core_reset;
    logic [NC-1:0]        core_start;
    logic [NC*BIB-1:0]    core_block_id;
    logic [NC*TFB-1:0]    core_thread_count;
    logic                 busy;
    logic                 done;
    logic [CB-1:0]        cycle_count;

    block_scheduler #(
        .NUM_CORES         (NC),
        .THREADS_PER_BLOCK (TPB),
        .THREAD_COUNT_BITS (TCB),
        .BLOCK_ID_BITS     (BIB),
        .CYCLE_BITS        (CB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_reset        (core_reset),
        .core_start        (core_start),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .busy              (busy),
        .done              (done),
        .cycle_count       (cycle_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: kernel 0 idle / 1 run / 2 done; core 0 free / 1 reset / 2 active / 3 abort-reset
    int     m_state;
    int     m_slot [NC];
    int     m_blk  [NC];
    int     m_tc   [NC];
    int     m_ptr, m_next, m_bdone, m_total, m_T;
    longint m_cyc;
    bit     m_start_q;
    int     seen_ids[$];
    int     seen_tcs[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_next = 0; m_bdone = 0; m_total = 0; m_T = 0;
        m_cyc = 0; m_start_q = 1'b0;
        for (int k = 0; k < NC; k++) begin
            m_slot[k] = 0; m_blk[k] = 0; m_tc[k] = 0;
        end
    endtask

    task automatic model_edge(input logic [NC-1:0] dn, input bit ab, input bit st, input int tc);
        int  old_slot [NC];
        bit  all_free;
        bit  found;
        int  j;
        all_free = 1'b1;
        for (int k = 0; k < NC; k++) begin
            old_slot[k] = m_slot[k];
            if (m_slot[k] != 0) all_free = 1'b0;
        end
        case (m_state)
            0: begin
                for (int k = 0; k < NC; k++) if (old_slot[k] == 3) m_slot[k] = 0;
                if (st && !m_start_q) begin
                    m_state = 1; m_T = tc; m_total = (tc + TPB - 1) / TPB;
                    m_next = 0; m_bdone = 0; m_cyc = 0;
                end
            end
            1: begin
                if (ab) begin
                    for (int k = 0; k < NC; k++) if (old_slot[k] != 0) m_slot[k] = 3;
                    m_state = 0;
                end else begin
                    if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
                    if (m_bdone == m_total && all_free) m_state = 2;
                    for (int k = 0; k < NC; k++) begin
                        if (old_slot[k] == 1) m_slot[k] = 2;
                        else if (old_slot[k] == 2 && dn[k]) begin
                            m_slot[k] = 0;
                            m_bdone++;
                        end
                    end
                    found = 1'b0;
                    if (m_next < m_total) begin
                        for (int i = 0; i < NC; i++) begin
                            j = (m_ptr + i) % NC;
                            if (!found && old_slot[j] == 0) begin
                                found = 1'b1;
                                m_slot[j] = 1;
                                m_blk[j]  = m_next;
                                m_tc[j]   = (m_next == m_total - 1) ? (m_T - (m_total - 1) * TPB) : TPB;
                                m_ptr     = (j + 1) % NC;
                                m_next++;
                            end
                        end
                    end
                end
            end
            default: if (!st) m_state = 0;
        endcase
        m_start_q = st;
    endtask

    task automatic check_outputs();
        logic [NC-1:0] exp_rst;
        logic [NC-1:0] exp_run;
        for (int k = 0; k < NC; k++) begin
            exp_rst[k] = (m_slot[k] == 1) || (m_slot[k] == 3);
            exp_run[k] = (m_slot[k] == 2);
        end
        chk("core_reset", core_reset, exp_rst);
        chk("core_start", core_start, exp_run);
        chk("busy", busy, m_state == 1);
        chk("done", done, m_state == 2);
        chk("cycle_count", cycle_count, m_cyc);
        for (int k = 0; k < NC; k++) begin
            if (m_slot[k] == 1) begin
                chk("block_id", core_block_id[k*BIB +: BIB], m_blk[k]);
                chk("block_threads", core_thread_count[k*TFB +: TFB], m_tc[k]);
                seen_ids.push_back(int'(core_block_id[k*BIB +: BIB]));
                seen_tcs.push_back(int'(core_thread_count[k*TFB +: TFB]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(core_done, abort, start, int'(thread_count));
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic rand_done();
        for (int k = 0; k < NC; k++) core_done[k] = ($urandom_range(0, 2) == 0);
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (m_state != 2 && n < budget) begin
            rand_done();
            tick();
            n++;
        end
        core_done = '0;
        chk("kernel_done_in_budget", done, 1'b1);
    endtask

    task automatic launch(input int t);
        start = 1'b1;
        thread_count = TCB'(t);
        tick();
        start = 1'b0;
    endtask

    int sel;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; thread_count = '0; core_done = '0;
        model_reset();
        #2;
        chk("rst_core_reset", core_reset, '0);
        chk("rst_core_start", core_start, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cycle_count", cycle_count, '0);
        chk("rst_block_id", core_block_id, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // T=10: third block goes to the core that finishes first (core 1)
        seen_ids.delete(); seen_tcs.delete();
        launch(10);
        repeat (3) tick();
        core_done = 2'b10;
        tick();
        core_done = '0;
        tick();
        chk("t10_third_core", core_reset, 2'b10);
        chk("t10_third_id", core_block_id[15:8], 8'd2);
        chk("t10_third_threads", core_thread_count[5:3], 3'd2);
        run_to_done(200);
        chk("t10_nblocks", seen_ids.size(), 3);
        if (seen_ids.size() == 3) begin
            chk("t10_id0", seen_ids[0], 0);
            chk("t10_id1", seen_ids[1], 1);
            chk("t10_tc0", seen_tcs[0], 4);
            chk("t10_tc1", seen_tcs[1], 4);
            chk("t10_tc2", seen_tcs[2], 2);
        end
        tick();

        // Zero-thread kernel
        launch(0);
        tick();
        chk("t0_done", done, 1'b1);
        chk("t0_cycles", cycle_count, 32'd1);
        chk("t0_no_reset", core_reset, 2'b00);
        tick();

        // Simultaneous completion on both cores with 4 blocks
        launch(16);
        repeat (3) tick();
        core_done = 2'b11;
        tick();
        core_done = '0;
        tick();
        chk("sim_one_reset_a", $countones(core_reset), 1);
        sel = core_reset[0] ? 0 : 1;
        chk("sim_block2", core_block_id[sel*BIB +: BIB], 8'd2);
        tick();
        chk("sim_one_reset_b", $countones(core_reset), 1);
        sel = core_reset[0] ? 0 : 1;
        chk("sim_block3", core_block_id[sel*BIB +: BIB], 8'd3);
        run_to_done(200);
        tick();

        // Randomized kernels
        for (int r = 0; r < 8; r++) begin
            launch($urandom_range(1, 60));
            run_to_done(600);
            tick();
        end

        // Abort 5 cycles into an 8-block run, then relaunch from block 0
        launch(32);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_kill", core_reset, 2'b11);
        chk("abort_start_low", core_start, 2'b00);
        chk("abort_busy", busy, 1'b0);
        repeat (3) tick();
        chk("abort_done_low", done, 1'b0);
        seen_ids.delete(); seen_tcs.delete();
        launch(32);
        tick();
        chk("relaunch_first_id", (seen_ids.size() > 0) ? seen_ids[0] : -1, 0);
        run_to_done(800);
        tick();

        // Start held high through DONE, then a single-block kernel
        start = 1'b1; thread_count = 8'd8;
        tick();
        run_to_done(300);
        repeat (3) tick();
        chk("held_done", done, 1'b1);
        start = 1'b0;
        tick();
        chk("drop_done", done, 1'b0);
        seen_ids.delete(); seen_tcs.delete();
        launch(4);
        run_to_done(200);
        chk("single_nblocks", seen_tcs.size(), 1);
        chk("single_tc", (seen_tcs.size() > 0) ? seen_tcs[0] : -1, 4);
        tick();

        // Asynchronous reset while cores are active
        launch(16);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("areset_core_start", core_start, '0);
        chk("areset_core_reset", core_reset, '0);
        chk("areset_busy", busy, 1'b0);
        chk("areset_block_id", core_block_id, '0);
        chk("areset_threads", core_thread_count, '0);
        model_reset();
        @(posedge clk);
        #1;
        chk("areset_hold_reset", core_reset, '0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_cycles", cycle_count, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
